// File: rtl/sram_nr1w_be.sv
// Block SRAM with NUM_READ_PORTS synchronous read ports and one byte-enabled write port.
// Read latency is 1 or 2 cycles; each port has a read_valid strobe. Reset clears only the read pipeline.
module sram_nr1w_be #(
  parameter int    DATA_WIDTH        = 32,
  parameter int    SIZE              = 1024,
  parameter int    NUM_READ_PORTS    = 2,
  parameter int    READ_LATENCY      = 1,
  parameter string READ_DURING_WRITE = "NEW_DATA",
  parameter int    ADDR_WIDTH        = $clog2(SIZE),
  parameter int    BYTES             = DATA_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_READ_PORTS-1:0]            read_en,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ_PORTS-1:0]            read_valid,
  input  logic                                 write_en,
  input  logic [ADDR_WIDTH-1:0]                write_addr,
  input  logic [BYTES-1:0]                     write_byte_en,
  input  logic [DATA_WIDTH-1:0]                write_data
);

  localparam bit NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");
  localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("sram_nr1w_be: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_nr1w_be: READ_LATENCY must be 1 or 2");
  end
  if (NUM_READ_PORTS < 1 || NUM_READ_PORTS > 4) begin : g_bad_ports
    $error("sram_nr1w_be: NUM_READ_PORTS must be 1..4");
  end
  if (READ_DURING_WRITE != "NEW_DATA" && READ_DURING_WRITE != "DONT_CARE") begin : g_bad_rdw
    $error("sram_nr1w_be: READ_DURING_WRITE must be NEW_DATA or DONT_CARE");
  end

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [DATA_WIDTH-1:0] write_mask;
  logic                  write_in_range;

  always_comb begin
    write_in_range = ({1'b0, write_addr} < SIZE_W);
    for (int b = 0; b < BYTES; b++) begin
      write_mask[8*b +: 8] = {8{write_byte_en[b]}};
    end
  end

  // Array contents are deliberately outside the reset domain; writes proceed even while reset is high.
  always_ff @(posedge clk) begin
    if (write_en && write_in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (write_byte_en[b]) begin
          mem[write_addr][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic                  in_range;
    logic                  hit;
    logic [DATA_WIDTH-1:0] array_word;
    logic [DATA_WIDTH-1:0] next_word;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign addr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Same-edge write forwarding is resolved here, before the first pipeline register.
    always_comb begin
      in_range   = ({1'b0, addr} < SIZE_W);
      hit        = write_en && write_in_range && (write_addr == addr);
      array_word = in_range ? mem[addr] : {DATA_WIDTH{1'bx}};
      if (!hit) begin
        next_word = array_word;
      end else if (NEW_DATA) begin
        next_word = (write_data & write_mask) | (array_word & ~write_mask);
      end else begin
        next_word = {DATA_WIDTH{1'bx}};
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_valid <= 1'b0;
        s1_data  <= {DATA_WIDTH{1'b0}};
      end else begin
        s1_valid <= read_en[p];
        if (read_en[p]) begin
          s1_data <= next_word;
        end
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_valid <= 1'b0;
          s2_data  <= {DATA_WIDTH{1'b0}};
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign read_valid[p]                         = s2_valid;
      assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = s2_data;
    end else begin : g_lat1
      assign read_valid[p]                         = s1_valid;
      assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = s1_data;
    end
  end

endmodule

// File: tb/tb_sram_nr1w_be.sv
// Bench for sram_nr1w_be: three configurations driven from vector tables, with a scoreboard
// queue that holds per-port expectations until the configured read latency has elapsed.
module tb_sram_nr1w_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // A: 2 ports, latency 1, NEW_DATA
  logic [1:0]  a_re;  logic [19:0] a_raddr; logic [63:0] a_rdata; logic [1:0] a_rvalid;
  logic        a_we;  logic [9:0]  a_waddr; logic [3:0]  a_wbe;   logic [31:0] a_wdata;
  // B: 4 ports, latency 2, NEW_DATA
  logic [3:0]  b_re;  logic [39:0] b_raddr; logic [127:0] b_rdata; logic [3:0] b_rvalid;
  logic        b_we;  logic [9:0]  b_waddr; logic [3:0]   b_wbe;   logic [31:0] b_wdata;
  // C: 1 port, latency 1, DONT_CARE, non-power-of-two size
  logic [0:0]  c_re;  logic [3:0]  c_raddr; logic [31:0] c_rdata; logic [0:0] c_rvalid;
  logic        c_we;  logic [3:0]  c_waddr; logic [3:0]  c_wbe;   logic [31:0] c_wdata;

  sram_nr1w_be #(.NUM_READ_PORTS(2), .READ_LATENCY(1), .READ_DURING_WRITE("NEW_DATA")) dut_a (
    .clk(clk), .reset(rst), .read_en(a_re), .read_addr(a_raddr), .read_data(a_rdata),
    .read_valid(a_rvalid), .write_en(a_we), .write_addr(a_waddr), .write_byte_en(a_wbe),
    .write_data(a_wdata));

  sram_nr1w_be #(.NUM_READ_PORTS(4), .READ_LATENCY(2), .READ_DURING_WRITE("NEW_DATA")) dut_b (
    .clk(clk), .reset(rst), .read_en(b_re), .read_addr(b_raddr), .read_data(b_rdata),
    .read_valid(b_rvalid), .write_en(b_we), .write_addr(b_waddr), .write_byte_en(b_wbe),
    .write_data(b_wdata));

  sram_nr1w_be #(.SIZE(12), .NUM_READ_PORTS(1), .READ_LATENCY(1), .READ_DURING_WRITE("DONT_CARE")) dut_c (
    .clk(clk), .reset(rst), .read_en(c_re), .read_addr(c_raddr), .read_data(c_rdata),
    .read_valid(c_rvalid), .write_en(c_we), .write_addr(c_waddr), .write_byte_en(c_wbe),
    .write_data(c_wdata));

  typedef struct {
    logic             we;
    logic [9:0]       waddr;
    logic [3:0]       wbe;
    logic [31:0]      wdata;
    logic [3:0]       re;
    logic [3:0][9:0]  raddr;
    logic [3:0][31:0] exp;
    logic [3:0]       dchk;
  } vec_t;

  typedef struct {
    logic [3:0]       v;
    logic [3:0]       dchk;
    logic [3:0][31:0] d;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   inst, lat, np;

  function automatic vec_t idle();
    vec_t v;
    v.we = 1'b0; v.waddr = 10'd0; v.wbe = 4'h0; v.wdata = 32'h0;
    v.re = 4'h0; v.raddr = 40'd0; v.exp = 128'd0; v.dchk = 4'hF;
    return v;
  endfunction

  function automatic vec_t wr(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    vec_t v = idle();
    v.we = 1'b1; v.waddr = a; v.wbe = be; v.wdata = d;
    return v;
  endfunction

  function automatic vec_t rd(input vec_t vi, input int p, input logic [9:0] a, input logic [31:0] d);
    vec_t v = vi;
    v.re[p] = 1'b1; v.raddr[p] = a; v.exp[p] = d;
    return v;
  endfunction

  function automatic vec_t nochk(input vec_t vi, input int p);
    vec_t v = vi;
    v.dchk[p] = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic set_phase(input int i, input int l, input int n);
    exp_t e;
    inst = i; lat = l; np = n;
    sbq.delete();
    e.v = 4'h0; e.dchk = 4'h0; e.d = 128'd0;
    for (int k = 0; k < l - 1; k++) sbq.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    case (inst)
      0: begin
        a_we = v.we; a_waddr = v.waddr; a_wbe = v.wbe; a_wdata = v.wdata;
        a_re = v.re[1:0]; a_raddr = v.raddr[1:0];
      end
      1: begin
        b_we = v.we; b_waddr = v.waddr; b_wbe = v.wbe; b_wdata = v.wdata;
        b_re = v.re; b_raddr = v.raddr;
      end
      default: begin
        c_we = v.we; c_waddr = v.waddr[3:0]; c_wbe = v.wbe; c_wdata = v.wdata;
        c_re = v.re[0]; c_raddr = v.raddr[0][3:0];
      end
    endcase
    for (int p = 0; p < 4; p++) e.v[p] = v.re[p] && (p < np);
    e.dchk = v.dchk;
    e.d    = v.exp;
    sbq.push_back(e);
  endtask

  task automatic sample(output logic [3:0] av, output logic [3:0][31:0] ad);
    case (inst)
      0:       begin av = {2'b00, a_rvalid};  ad = {64'd0, a_rdata}; end
      1:       begin av = b_rvalid;           ad = b_rdata;          end
      default: begin av = {3'b000, c_rvalid}; ad = {96'd0, c_rdata}; end
    endcase
  endtask

  task automatic step(input string tag);
    exp_t             e;
    logic [3:0]       av;
    logic [3:0][31:0] ad;
    @(posedge clk);
    #1;
    if (sbq.size() >= lat) begin
      e = sbq.pop_front();
      sample(av, ad);
      for (int p = 0; p < np; p++) begin
        check($sformatf("%s p%0d valid", tag, p), 32'(av[p]), 32'(e.v[p]));
        if (e.v[p] && e.dchk[p]) check($sformatf("%s p%0d data", tag, p), ad[p], e.d[p]);
      end
    end
  endtask

  task automatic run_table(input string pfx);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      step($sformatf("%s%0d", pfx, i));
    end
  endtask

  initial begin
    rst = 1'b0;
    a_re = '0; a_raddr = '0; a_we = 1'b0; a_waddr = '0; a_wbe = '0; a_wdata = '0;
    b_re = '0; b_raddr = '0; b_we = 1'b0; b_waddr = '0; b_wbe = '0; b_wdata = '0;
    c_re = '0; c_raddr = '0; c_we = 1'b0; c_waddr = '0; c_wbe = '0; c_wdata = '0;
    #2 rst = 1'b1;
    #1;
    check("reset A valid", 32'(a_rvalid), 32'd0);
    check("reset A data",  32'(|a_rdata), 32'd0);
    check("reset B valid", 32'(b_rvalid), 32'd0);
    check("reset B data",  32'(|b_rdata), 32'd0);
    check("reset C valid", 32'(c_rvalid), 32'd0);
    check("reset C data",  32'(|c_rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // A: basic write/read, byte merge, same-edge collisions with partial and empty lane masks
    set_phase(0, 1, 2);
    tbl.delete();
    tbl.push_back(wr(10'd5, 4'hF, 32'hDEADBEEF));
    tbl.push_back(rd(wr(10'd7, 4'hF, 32'h11223344), 0, 10'd5, 32'hDEADBEEF));
    tbl.push_back(wr(10'd7, 4'b0101, 32'hAABBCCDD));
    tbl.push_back(rd(wr(10'd9, 4'hF, 32'h00000000), 0, 10'd7, 32'h11BB33DD));
    tbl.push_back(rd(wr(10'd9, 4'b1100, 32'hCAFEF00D), 1, 10'd9, 32'hCAFE0000));
    tbl.push_back(rd(rd(wr(10'd9, 4'b0000, 32'hFFFFFFFF), 0, 10'd9, 32'hCAFE0000), 1, 10'd7, 32'h11BB33DD));
    tbl.push_back(rd(rd(idle(), 0, 10'd5, 32'hDEADBEEF), 1, 10'd5, 32'hDEADBEEF));
    tbl.push_back(idle());
    run_table("A");

    // B: latency-2 streaming, write after read, 4-port broadcast and spread, stage-1 bypass
    set_phase(1, 2, 4);
    tbl.delete();
    tbl.push_back(wr(10'd0, 4'hF, 32'h10));
    tbl.push_back(wr(10'd1, 4'hF, 32'h11));
    tbl.push_back(wr(10'd2, 4'hF, 32'h12));
    tbl.push_back(wr(10'd3, 4'hF, 32'h13));
    tbl.push_back(rd(idle(), 0, 10'd0, 32'h10));
    tbl.push_back(rd(idle(), 0, 10'd1, 32'h11));
    tbl.push_back(rd(wr(10'd1, 4'hF, 32'h55), 0, 10'd2, 32'h12));
    tbl.push_back(rd(idle(), 0, 10'd3, 32'h13));
    tbl.push_back(rd(rd(rd(rd(idle(), 0, 10'd3, 32'h13), 1, 10'd3, 32'h13), 2, 10'd3, 32'h13), 3, 10'd3, 32'h13));
    tbl.push_back(rd(rd(rd(rd(idle(), 0, 10'd0, 32'h10), 1, 10'd1, 32'h55), 2, 10'd2, 32'h12), 3, 10'd3, 32'h13));
    tbl.push_back(rd(wr(10'd1, 4'b1000, 32'h66000000), 1, 10'd1, 32'h66000055));
    tbl.push_back(idle());
    tbl.push_back(idle());
    run_table("B");

    // B: reset while two reads sit in the pipeline, with a write landing during reset
    drive(rd(rd(idle(), 0, 10'd0, 32'h10), 1, 10'd3, 32'h13));
    step("B issue");
    drive(idle());
    #1 rst = 1'b1;
    b_we = 1'b1; b_waddr = 10'd4; b_wbe = 4'hF; b_wdata = 32'hABCD1234;
    #1;
    check("B midrst valid", 32'(b_rvalid), 32'd0);
    check("B midrst data",  32'(|b_rdata), 32'd0);
    @(posedge clk);
    #1;
    b_we = 1'b0;
    rst  = 1'b0;
    set_phase(1, 2, 4);
    tbl.delete();
    tbl.push_back(idle());
    tbl.push_back(idle());
    tbl.push_back(rd(rd(rd(rd(idle(), 0, 10'd0, 32'h10), 1, 10'd1, 32'h66000055), 2, 10'd4, 32'hABCD1234), 3, 10'd3, 32'h13));
    tbl.push_back(idle());
    tbl.push_back(idle());
    run_table("Bpost");

    // C: DONT_CARE collision and out-of-range accesses still strobe valid
    set_phase(2, 1, 1);
    tbl.delete();
    tbl.push_back(wr(10'd2, 4'hF, 32'h12345678));
    tbl.push_back(nochk(rd(wr(10'd2, 4'hF, 32'hFFFFFFFF), 0, 10'd2, 32'h0), 0));
    tbl.push_back(rd(idle(), 0, 10'd2, 32'hFFFFFFFF));
    tbl.push_back(nochk(rd(wr(10'd13, 4'hF, 32'h0), 0, 10'd14, 32'h0), 0));
    tbl.push_back(rd(idle(), 0, 10'd2, 32'hFFFFFFFF));
    tbl.push_back(idle());
    run_table("C");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
